// File: rtl/stream_converge_arbiter_if.sv
// Bundle of the freespace-update, data-queue, credit and output-stream
// signals of the BFT leaf converge arbiter.
interface stream_converge_arbiter_if #(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_IN_PORTS  = 7,
  parameter int NUM_OUT_PORTS = 7,
  parameter int CREDIT_BITS   = 8
);
  logic                                   resend;
  logic [NUM_IN_PORTS-1:0]                upd_req;
  logic [PACKET_BITS*NUM_IN_PORTS-1:0]    upd_pkt;
  logic [NUM_IN_PORTS-1:0]                upd_ack;
  logic [PACKET_BITS*NUM_OUT_PORTS-1:0]   out_pkt;
  logic [NUM_OUT_PORTS-1:0]               out_empty;
  logic [NUM_OUT_PORTS-1:0]               out_rd_en;
  logic [NUM_OUT_PORTS-1:0]               credit_ret;
  logic [CREDIT_BITS*NUM_OUT_PORTS-1:0]   credit_out;
  logic [PACKET_BITS-1:0]                 stream_out;

  // Arbiter side
  modport slave (
    input  resend, upd_req, upd_pkt, out_pkt, out_empty, credit_ret,
    output upd_ack, out_rd_en, credit_out, stream_out
  );

  // Environment side (port clusters, downstream switch)
  modport master (
    output resend, upd_req, upd_pkt, out_pkt, out_empty, credit_ret,
    input  upd_ack, out_rd_en, credit_out, stream_out
  );
endinterface

// File: rtl/stream_converge_arbiter.sv
// Merges freespace updates (fixed priority) and credit-gated data packets
// (round-robin) onto one registered stream, with level-sensitive replay of
// the last non-idle packet sent.
module stream_converge_arbiter #(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_IN_PORTS  = 7,
  parameter int NUM_OUT_PORTS = 7,
  parameter int CREDIT_BITS   = 8,
  parameter int INIT_CREDIT   = 64,
  parameter int CREDIT_RETURN = 64
) (
  input  logic                        clk_bft,
  input  logic                        reset_bft_n,
  stream_converge_arbiter_if.slave    bus
);

  localparam int RR_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [CREDIT_BITS:0] CRED_RET = (CREDIT_BITS+1)'(CREDIT_RETURN);

  typedef enum logic {ST_RUN, ST_RESEND} state_t;

  state_t                    state;
  logic [PACKET_BITS-1:0]    stream_q, stream_d;
  logic [PACKET_BITS-1:0]    last_q, last_d;
  logic [RR_W-1:0]           rr_q, rr_d;
  logic [CREDIT_BITS-1:0]    credit_q [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]    credit_d [NUM_OUT_PORTS];
  logic [CREDIT_BITS:0]      credit_sum [NUM_OUT_PORTS];
  logic [NUM_IN_PORTS-1:0]   upd_ack;
  logic [NUM_OUT_PORTS-1:0]  rd_en;
  logic [NUM_OUT_PORTS-1:0]  elig;
  logic                      found;
  logic [CREDIT_BITS*NUM_OUT_PORTS-1:0] credit_flat;

  // State follows the resend level with no transition cycles, so it is
  // decoded directly rather than held in a flop.
  always_comb begin
    state = bus.resend ? ST_RESEND : ST_RUN;
  end

  // Per-cycle arbitration: resend > freespace update > round-robin data
  always_comb begin
    upd_ack  = '0;
    rd_en    = '0;
    stream_d = '0;
    last_d   = last_q;
    rr_d     = rr_q;
    found    = 1'b0;
    elig     = '0;
    for (int unsigned j = 0; j < NUM_OUT_PORTS; j++) begin
      elig[j] = !bus.out_empty[j] && (credit_q[j] != '0);
    end
    if (reset_bft_n) begin
      if (state == ST_RESEND) begin
        stream_d = last_q;
      end else if (|bus.upd_req) begin
        for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
          if (!found && bus.upd_req[i]) begin
            found      = 1'b1;
            upd_ack[i] = 1'b1;
            stream_d   = bus.upd_pkt[i*PACKET_BITS +: PACKET_BITS];
          end
        end
      end else begin
        // Rotating priority split into two linear scans: ports at/after rr,
        // then ports below rr.
        for (int unsigned j = 0; j < NUM_OUT_PORTS; j++) begin
          if (!found && elig[j] && (RR_W'(j) >= rr_q)) begin
            found    = 1'b1;
            rd_en[j] = 1'b1;
            stream_d = bus.out_pkt[j*PACKET_BITS +: PACKET_BITS];
            rr_d     = (j == unsigned'(NUM_OUT_PORTS-1)) ? '0 : RR_W'(j + 1);
          end
        end
        for (int unsigned j = 0; j < NUM_OUT_PORTS; j++) begin
          if (!found && elig[j] && (RR_W'(j) < rr_q)) begin
            found    = 1'b1;
            rd_en[j] = 1'b1;
            stream_d = bus.out_pkt[j*PACKET_BITS +: PACKET_BITS];
            rr_d     = (j == unsigned'(NUM_OUT_PORTS-1)) ? '0 : RR_W'(j + 1);
          end
        end
      end
      if ((state == ST_RUN) && (|stream_d)) begin
        last_d = stream_d;
      end
    end
  end

  // Credit update: add return, subtract grant, saturate at all-ones
  always_comb begin
    for (int unsigned j = 0; j < NUM_OUT_PORTS; j++) begin
      credit_sum[j] = {1'b0, credit_q[j]}
                    + (bus.credit_ret[j] ? CRED_RET : '0)
                    - {{CREDIT_BITS{1'b0}}, rd_en[j]};
      credit_d[j]   = credit_sum[j][CREDIT_BITS] ? '1
                                                 : credit_sum[j][CREDIT_BITS-1:0];
    end
  end

  // Registered stream, replay buffer, rr pointer and credits
  always_ff @(posedge clk_bft or negedge reset_bft_n) begin
    if (!reset_bft_n) begin
      stream_q <= '0;
      last_q   <= '0;
      rr_q     <= '0;
      for (int unsigned j = 0; j < NUM_OUT_PORTS; j++) begin
        credit_q[j] <= CREDIT_BITS'(INIT_CREDIT);
      end
    end else begin
      stream_q <= stream_d;
      last_q   <= last_d;
      rr_q     <= rr_d;
      for (int unsigned j = 0; j < NUM_OUT_PORTS; j++) begin
        credit_q[j] <= credit_d[j];
      end
    end
  end

  // Flatten credits for observation
  always_comb begin
    credit_flat = '0;
    for (int unsigned j = 0; j < NUM_OUT_PORTS; j++) begin
      credit_flat[j*CREDIT_BITS +: CREDIT_BITS] = credit_q[j];
    end
  end

  assign bus.upd_ack    = upd_ack;
  assign bus.out_rd_en  = rd_en;
  assign bus.credit_out = credit_flat;
  assign bus.stream_out = stream_q;

endmodule

// File: tb/tb_stream_converge_arbiter.sv
// Directed bench for stream_converge_arbiter: expected stream packets are
// queued when a grant is expected and compared one cycle later.
module tb_stream_converge_arbiter;
  localparam int PB = 97;
  localparam int NI = 7;
  localparam int NO = 7;
  localparam int CB = 8;

  logic clk_bft = 1'b0;
  logic reset_bft_n = 1'b0;
  always #5 clk_bft = ~clk_bft;

  stream_converge_arbiter_if #(.PACKET_BITS(PB), .NUM_IN_PORTS(NI),
                               .NUM_OUT_PORTS(NO), .CREDIT_BITS(CB)) bus ();

  stream_converge_arbiter #(
    .PACKET_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO),
    .CREDIT_BITS(CB), .INIT_CREDIT(64), .CREDIT_RETURN(64)
  ) dut (
    .clk_bft    (clk_bft),
    .reset_bft_n(reset_bft_n),
    .bus        (bus)
  );

  logic [PB-1:0] q_head [NO];
  logic [PB-1:0] sb [$];
  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NO; g++) begin : g_heads
    assign bus.out_pkt[g*PB +: PB] = q_head[g];
  end

  task automatic chk(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cred(input int j, input int exp);
    chk($sformatf("credit%0d", j), PB'(bus.credit_out[j*CB +: CB]), PB'(exp));
  endtask

  // One arbitration cycle: check combinational strobes and the stream value
  // registered last cycle, queue this cycle's expected packet, advance the
  // modelled FWFT heads for expected pops.
  task automatic step(input logic [NI-1:0] e_ack, input logic [NO-1:0] e_rd,
                      input logic [PB-1:0] e_pkt, input string tag);
    logic [PB-1:0] e;
    @(negedge clk_bft);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    chk({tag, " stream_out"}, bus.stream_out, e);
    chk({tag, " upd_ack"}, PB'(bus.upd_ack), PB'(e_ack));
    chk({tag, " out_rd_en"}, PB'(bus.out_rd_en), PB'(e_rd));
    sb.push_back(e_pkt);
    @(posedge clk_bft);
    #1;
    for (int j = 0; j < NO; j++) begin
      if (e_rd[j]) q_head[j] = q_head[j] + 1'b1;
    end
  endtask

  initial begin
    logic [PB-1:0] u1, u2, pa;
    int order [6];
    int p;
    order = '{0, 2, 5, 0, 2, 5};
    u1 = {1'b1, 96'h11};
    u2 = {1'b1, 96'h22};
    pa = {1'b1, 96'hAB};
    bus.resend     = 1'b0;
    bus.upd_req    = '0;
    bus.upd_pkt    = '0;
    bus.out_empty  = '1;
    bus.credit_ret = '0;
    for (int j = 0; j < NO; j++) q_head[j] = {1'b1, 4'(j), 92'd0};

    // Reset values
    #12;
    chk("reset stream_out", bus.stream_out, '0);
    chk("reset upd_ack", PB'(bus.upd_ack), '0);
    chk("reset out_rd_en", PB'(bus.out_rd_en), '0);
    for (int j = 0; j < NO; j++) chk_cred(j, 64);
    @(negedge clk_bft);
    reset_bft_n = 1'b1;
    @(posedge clk_bft);
    #1;
    sb.push_back('0);

    // Idle
    repeat (3) step('0, '0, '0, "idle");

    // Round-robin over ports 0, 2, 5
    bus.out_empty = 7'b1011010;
    for (int k = 0; k < 6; k++) begin
      p = order[k];
      step('0, 7'(1) << p, q_head[p], "rr");
    end
    bus.out_empty = '1;
    chk_cred(0, 62); chk_cred(2, 62); chk_cred(5, 62); chk_cred(1, 64);

    // Updates take priority over pending data, lowest index first
    bus.upd_pkt[1*PB +: PB] = u1;
    bus.upd_pkt[2*PB +: PB] = u2;
    bus.upd_req   = 7'b0000110;
    bus.out_empty = 7'b1111110;
    step(7'b0000010, '0, u1, "upd1");
    bus.upd_req = 7'b0000100;
    step(7'b0000100, '0, u2, "upd2");
    bus.upd_req = '0;
    step('0, 7'b0000001, q_head[0], "upd data");
    bus.out_empty = '1;

    // Exhaust port 3 credit, then a return restores it
    bus.out_empty = 7'b1110111;
    for (int k = 0; k < 64; k++) step('0, 7'b0001000, q_head[3], "drain");
    step('0, '0, '0, "zero credit");
    chk_cred(3, 0);
    bus.credit_ret = 7'b0001000;
    step('0, '0, '0, "credit return");
    bus.credit_ret = '0;
    chk_cred(3, 64);
    step('0, 7'b0001000, q_head[3], "resume");
    bus.out_empty = '1;
    chk_cred(3, 63);

    // Resend replays the last packet and blocks grants
    bus.upd_pkt[0 +: PB] = pa;
    bus.upd_req = 7'b0000001;
    step(7'b0000001, '0, pa, "send A");
    bus.upd_req   = '0;
    bus.out_empty = 7'b1111110;
    bus.resend    = 1'b1;
    repeat (3) step('0, '0, pa, "resend");
    bus.resend = 1'b0;
    step('0, 7'b0000001, q_head[0], "after resend");
    bus.out_empty = '1;

    // Credit saturation on port 1
    bus.credit_ret = 7'b0000010;
    repeat (3) step('0, '0, '0, "ret1");
    bus.credit_ret = '0;
    chk_cred(1, 255);
    bus.out_empty = 7'b1111101;
    repeat (5) step('0, 7'b0000010, q_head[1], "pop1");
    chk_cred(1, 250);
    bus.credit_ret = 7'b0000010;
    step('0, 7'b0000010, q_head[1], "ret+grant");
    bus.credit_ret = '0;
    bus.out_empty  = '1;
    chk_cred(1, 255);
    step('0, '0, '0, "flush");

    // Reset asserted with a grant pending drops the packet
    bus.out_empty = 7'b1111110;
    @(negedge clk_bft);
    chk("pre-reset out_rd_en", PB'(bus.out_rd_en), PB'(7'b0000001));
    reset_bft_n = 1'b0;
    #1;
    chk("in-reset out_rd_en", PB'(bus.out_rd_en), '0);
    @(posedge clk_bft);
    #1;
    chk("in-reset stream_out", bus.stream_out, '0);
    chk_cred(0, 64);
    chk_cred(1, 64);
    bus.out_empty = '1;
    sb.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_converge_arbiter.md
# stream_converge_arbiter

Parametrised successor to the BFT leaf converge controller. Merges freespace-update packets from the input-port cluster and data packets from the output-port cluster onto the single `stream_out` toward the BFT switch. Adds three behaviours the current controller lacks:
- round-robin fairness across output ports;
- per-output-port credit counters that stop a port from sending beyond downstream buffer space;
- a level-sensitive resend replay of the last transmitted packet.

## Interface
- `PACKET_BITS`, 97: packet width; bit `PACKET_BITS-1` is the valid flag, all-zero packet = idle.
- `NUM_IN_PORTS`, 7: freespace-update sources.
- `NUM_OUT_PORTS`, 7: data sources (FWFT queues).
- `CREDIT_BITS`, 8: width of each credit counter.
- `INIT_CREDIT`, 64: credit loaded at reset; must be < 2^CREDIT_BITS.
- `CREDIT_RETURN`, 64: credit added per `credit_ret` pulse.

Ports:
- `clk_bft`  in  1  single clock.
- `reset_bft_n`  in  1  asynchronous, active-low reset.
- `resend`  in  1  level; while high, replay the last sent packet.
- `upd_req`  in  NUM_IN_PORTS  freespace-update request per input port; held until acked.
- `upd_pkt`  in  PACKET_BITS*NUM_IN_PORTS  update packets; port i at slice i.
- `upd_ack`  out  NUM_IN_PORTS  one-cycle one-hot acceptance.
- `out_pkt`  in  PACKET_BITS*NUM_OUT_PORTS  head-of-queue packets, FWFT.
- `out_empty`  in  NUM_OUT_PORTS  queue empty flags.
- `out_rd_en`  out  NUM_OUT_PORTS  one-hot pop strobe.
- `credit_ret`  in  NUM_OUT_PORTS  one-cycle pulse; downstream freed CREDIT_RETURN slots for port i.
- `credit_out`  out  CREDIT_BITS*NUM_OUT_PORTS  current credit per port, for observation.
- `stream_out`  out  PACKET_BITS  registered packet to the switch.

## Operation
- Per-cycle priority: resend > freespace update > data.
- **RESEND state** (entered while `resend`=1):
  - `stream_out` <= `last_pkt`; no ack, no pop, no credit change.
  - If nothing has been sent since reset, `last_pkt` = 0, so idle is replayed.
- **RUN state** (`resend`=0):
  - Any `upd_req` set: grant the lowest-index i. `upd_ack[i]`=1 and `stream_out` <= `upd_pkt[i]`.
  - No updates pending: eligible data ports are those with `!out_empty[j]` and `credit[j]!=0`. Round-robin from pointer `rr`; the first eligible j at or after `rr` (mod NUM_OUT_PORTS) wins.
  - On a data win: `out_rd_en[j]`=1, `stream_out` <= `out_pkt[j]`, `credit[j]` decrements by 1, `rr` <= j+1 (wraps to 0 after NUM_OUT_PORTS-1).
  - Nothing eligible: `stream_out` <= 0; `rr` unchanged.
- FSM is RUN <-> RESEND, driven purely by the `resend` level. No extra cycles on either transition.
- `last_pkt` updates on every non-idle packet sent in RUN. It never updates in RESEND or on an idle cycle.
- Credit arithmetic, per port, each cycle: `credit` + (`credit_ret` ? CREDIT_RETURN : 0) − (grant ? 1 : 0).
  - Computed at CREDIT_BITS+1 width, then saturated at 2^CREDIT_BITS−1.
  - A return and a grant in the same cycle net to +CREDIT_RETURN−1.
- `credit_ret` is honoured in every state, including RESEND.
- A port with zero credit is skipped: no pop, and `rr` is not advanced past it on its account.

## Timing
- Reset values (async assert):
  - `stream_out`=0, `upd_ack`=0, `out_rd_en`=0, `last_pkt`=0;
  - every credit = INIT_CREDIT, `rr`=0, state RUN.
- Reset release is synchronous-safe; the first arbitration happens on the first clk_bft edge after deassertion.
- `upd_ack` and `out_rd_en` are combinational from the current-cycle decision. Queue data is valid in the same cycle; the pop takes effect at the clock edge.
- Latency: `stream_out` is registered, so the granted packet appears 1 cycle after the ack or rd_en cycle.
- Throughput: one packet per cycle. A continuous update stream starves data; this is intended, since updates are small and bounded.
- `resend` is sampled each cycle. It is effective 1 cycle later on `stream_out`, with no grant issued in the sampled cycle.
- `reset_bft_n` asserted mid-packet: all state clears immediately and any granted-but-unregistered packet is dropped. Upstream queues are reset in the same domain.

## Test plan
- Reset then idle (all `out_empty`=1, `upd_req`=0) -> `stream_out`=0 every cycle; `credit_out` all 64.
- Ports 0, 2, 5 non-empty for 6 cycles -> `out_rd_en` order 0, 2, 5, 0, 2, 5; each `stream_out` equals that port's head 1 cycle later; credits 62, 62, 62.
- `upd_req`=0b0000110 with data pending -> ack port 1, then port 2; data pops only after both acks.
- INIT_CREDIT=2, port 3 alone non-empty -> two pops, then `stream_out`=0. A `credit_ret[3]` pulse gives credit 64, and pops resume the next cycle.
- Send packet 0x1_00..AB, then hold `resend` high for 3 cycles while port 0 is non-empty -> `stream_out`=0x1_00..AB for 3 cycles, no `out_rd_en`; port 0 pops on the cycle `resend` falls.
- `credit_ret[1]` plus grant of port 1 at credit 250 (CREDIT_BITS=8) -> credit saturates to 255, not wrapping.
